// File: rtl/tdm_demux8_pkg.sv
// tdm_demux8_pkg
// Shared constants for the TDM receive demultiplexer: frame geometry
// (slots per frame, slot index width, beat width) and the FSM state codes.
package tdm_demux8_pkg;

  localparam int CHANNELS = 8;                 // slots per frame
  localparam int SEL_W    = 3;                 // log2(CHANNELS)
  localparam int DATA_W   = 1;                 // width of one slot beat
  localparam int FRAME_W  = CHANNELS * DATA_W; // width of an assembled frame

  // FSM state codes
  localparam logic [0:0] ST_IDLE = 1'b0;       // waiting for a slot-0 beat
  localparam logic [0:0] ST_RECV = 1'b1;       // frame in progress

endpackage : tdm_demux8_pkg

// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if
// Bus between a TDM transmitter (master) and the demultiplexer (slave).
//   in_valid    : master -> slave, beat on din is valid this cycle
//   frame_start : master -> slave, valid beat is slot 0
//   din         : master -> slave, serial beat
//   sel         : slave -> master, slot index the next valid beat fills
//   busy        : slave -> master, frame in progress
//   dout        : slave -> master, last complete frame (channel i at [i*DATA_W +: DATA_W])
//   frame_valid : slave -> master, one-cycle pulse, dout just updated
//   frame_err   : slave -> master, one-cycle pulse, partial frame discarded
interface tdm_demux8_if;
  import tdm_demux8_pkg::*;

  logic               in_valid;
  logic               frame_start;
  logic [DATA_W-1:0]  din;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic [FRAME_W-1:0] dout;
  logic               frame_valid;
  logic               frame_err;

  modport master (
    output in_valid, frame_start, din,
    input  sel, busy, dout, frame_valid, frame_err
  );

  modport slave (
    input  in_valid, frame_start, din,
    output sel, busy, dout, frame_valid, frame_err
  );

endinterface : tdm_demux8_if

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter
// Slot index counter for the TDM demultiplexer.
//   clk     : clock
//   i_clr   : synchronous clear to 0 (highest priority)
//   i_load1 : load 1 (a slot-0 beat was just captured)
//   i_inc   : increment; the last slot wraps naturally back to 0
//   o_sel   : current slot index
//   o_tc    : terminal count, o_sel is the last slot
module tdm_slot_counter
  import tdm_demux8_pkg::*;
(
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_tc
);

  logic [SEL_W-1:0] r_sel;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_sel <= '0;
    end else if (i_load1) begin
      r_sel <= SEL_W'(1);
    end else if (i_inc) begin
      r_sel <= r_sel + SEL_W'(1);
    end
  end

  assign o_sel = r_sel;
  assign o_tc  = (r_sel == SEL_W'(CHANNELS - 1));

endmodule : tdm_slot_counter

// File: rtl/tdm_demux8.sv
// tdm_demux8
// Receive-side TDM demultiplexer. Collects eight serial beats (slot 0
// marked by frame_start) into a shadow register and publishes the
// complete frame on dout with a one-cycle frame_valid pulse. A new
// frame_start in the middle of a frame discards the partial frame,
// pulses frame_err and restarts collection with that beat as slot 0.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : tdm_demux8_if slave modport (see interface header)
module tdm_demux8
  import tdm_demux8_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  tdm_demux8_if.slave  bus
);

  logic [0:0]         r_state;
  logic [FRAME_W-1:0] r_shadow;
  logic [FRAME_W-1:0] r_dout;
  logic               r_frame_valid;
  logic               r_frame_err;

  logic [SEL_W-1:0]   w_sel;
  logic               w_tc;
  logic               w_load0;   // valid slot-0 beat (start or resync)
  logic               w_cap;     // valid continuation beat inside a frame
  logic               w_last;    // continuation beat that fills the last slot
  logic [CHANNELS-1:0] w_wr_en;
  logic [FRAME_W-1:0] w_frame;

  // frame_start is honoured in either state; a plain beat only counts
  // while a frame is open, so stray beats in IDLE are silently dropped.
  assign w_load0 = bus.in_valid & bus.frame_start;
  assign w_cap   = bus.in_valid & ~bus.frame_start & (r_state == ST_RECV);
  assign w_last  = w_cap & w_tc;

  tdm_slot_counter u_slot_counter (
    .clk     (clk),
    .i_clr   (rst),
    .i_load1 (w_load0),
    .i_inc   (w_cap),
    .o_sel   (w_sel),
    .o_tc    (w_tc)
  );

  // Per-slot write enables, and the completed frame: the last slot comes
  // straight from din so dout updates on the same edge that samples it.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
      if (gi == 0) begin : g_first
        assign w_wr_en[gi] = w_load0 | (w_cap & (w_sel == SEL_W'(gi)));
      end else begin : g_rest
        assign w_wr_en[gi] = w_cap & (w_sel == SEL_W'(gi));
      end
      if (gi == CHANNELS - 1) begin : g_last
        assign w_frame[gi*DATA_W +: DATA_W] = bus.din;
      end else begin : g_prev
        assign w_frame[gi*DATA_W +: DATA_W] = r_shadow[gi*DATA_W +: DATA_W];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wr_en[i]) begin
          r_shadow[i*DATA_W +: DATA_W] <= bus.din;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load0) begin
            r_state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (w_load0) begin
            // resync: old partial frame is dropped, dout untouched
            r_frame_err <= 1'b1;
          end else if (w_last) begin
            r_dout        <= w_frame;
            r_frame_valid <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel         = w_sel;
  assign bus.busy        = (r_state == ST_RECV);
  assign bus.dout        = r_dout;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;

endmodule : tdm_demux8

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8
// Self-checking bench for tdm_demux8: a directed vector table, hand-written
// multi-cycle sequences (gap, resync, reset mid-frame), then random traffic
// compared against a queue-based frame-collector model.
module tb_tdm_demux8;
  import tdm_demux8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux8_if bus ();

  tdm_demux8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  bit         m_open;       // a frame is being collected
  bit         m_beats[$];   // beats gathered so far, slot order
  logic [7:0] m_dout;
  bit         m_fv, m_fe;

  task automatic model_step(input logic r, input logic v, input logic fs, input logic d);
    m_fv = 0;
    m_fe = 0;
    if (r) begin
      m_open = 0;
      m_beats.delete();
      m_dout = 8'h00;
    end else if (v) begin
      if (fs) begin
        if (m_open) m_fe = 1;
        m_open = 1;
        m_beats.delete();
        m_beats.push_back(d);
      end else if (m_open) begin
        m_beats.push_back(d);
        if (m_beats.size() == CHANNELS) begin
          for (int i = 0; i < CHANNELS; i++) m_dout[i] = m_beats[i];
          m_fv = 1;
          m_open = 0;
          m_beats.delete();
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int sel, input int busy,
                         input int dout, input int fv, input int fe);
    chk({tag, ".sel"},         int'(bus.sel),         sel);
    chk({tag, ".busy"},        int'(bus.busy),        busy);
    chk({tag, ".dout"},        int'(bus.dout),        dout);
    chk({tag, ".frame_valid"}, int'(bus.frame_valid), fv);
    chk({tag, ".frame_err"},   int'(bus.frame_err),   fe);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_beats.size(), int'(m_open), int'(m_dout), int'(m_fv), int'(m_fe));
  endtask

  // one clock: drive, let the edge sample, then settle 1 time unit
  task automatic step(input logic r, input logic v, input logic fs, input logic d);
    rst             = r;
    bus.in_valid    = v;
    bus.frame_start = fs;
    bus.din         = d;
    @(posedge clk);
    model_step(r, v, fs, d);
    #1;
    $display("cyc t=%0t rst=%0b v=%0b fs=%0b din=%0b -> sel=%0d busy=%0b dout=%02h fv=%0b fe=%0b",
             $time, r, v, fs, d, bus.sel, bus.busy, bus.dout, bus.frame_valid, bus.frame_err);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v, fs, din;
    int         sel, busy;
    logic [7:0] dout;
    int         fv, fe;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic fs, input logic din, input int sel,
                              input int busy, input logic [7:0] dout, input int fv, input int fe);
    vec_t e;
    e.v = v; e.fs = fs; e.din = din; e.sel = sel; e.busy = busy;
    e.dout = dout; e.fv = fv; e.fe = fe;
    tbl.push_back(e);
  endfunction

  logic [7:0] pat, pat2;

  initial begin
    // frame 8'hB6 (slots 0..7 = 0,1,1,0,1,1,0,1), no gaps
    add(1,1,0, 1,1,8'h00,0,0);
    add(1,0,1, 2,1,8'h00,0,0);
    add(1,0,1, 3,1,8'h00,0,0);
    add(1,0,0, 4,1,8'h00,0,0);
    add(1,0,1, 5,1,8'h00,0,0);
    add(1,0,1, 6,1,8'h00,0,0);
    add(1,0,0, 7,1,8'h00,0,0);
    add(1,0,1, 0,0,8'hB6,1,0);
    // back-to-back frame 8'h5A (slots 0..7 = 0,1,0,1,1,0,1,0)
    add(1,1,0, 1,1,8'hB6,0,0);
    add(1,0,1, 2,1,8'hB6,0,0);
    add(1,0,0, 3,1,8'hB6,0,0);
    add(1,0,1, 4,1,8'hB6,0,0);
    add(1,0,1, 5,1,8'hB6,0,0);
    add(1,0,0, 6,1,8'hB6,0,0);
    add(1,0,1, 7,1,8'hB6,0,0);
    add(1,0,0, 0,0,8'h5A,1,0);
    // stray beats in IDLE are dropped
    add(1,0,1, 0,0,8'h5A,0,0);
    add(1,0,1, 0,0,8'h5A,0,0);
    add(0,0,0, 0,0,8'h5A,0,0);

    // reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_all("reset", 0, 0, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(0, tbl[k].v, tbl[k].fs, tbl[k].din);
      chk_all($sformatf("tbl%0d", k), tbl[k].sel, tbl[k].busy, int'(tbl[k].dout),
              tbl[k].fv, tbl[k].fe);
    end

    // gap of 3 idle cycles after slot 3
    pat = 8'hB6;
    for (int k = 0; k < 4; k++) step(0, 1, k == 0, pat[k]);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      chk_all("gap_hold", 4, 1, 8'h5A, 0, 0);
    end
    for (int k = 4; k < 8; k++) step(0, 1, 0, pat[k]);
    chk_all("gap_done", 0, 0, 8'hB6, 1, 0);
    step(0, 0, 0, 0);
    chk_all("gap_after", 0, 0, 8'hB6, 0, 0);

    // resync: frame_start on beat 5 of a frame
    pat  = 8'h5A;
    pat2 = 8'h3C;
    for (int k = 0; k < 5; k++) step(0, 1, k == 0, pat[k]);
    step(0, 1, 1, pat2[0]);
    chk_all("resync", 1, 1, 8'hB6, 0, 1);
    for (int k = 1; k < 8; k++) begin
      step(0, 1, 0, pat2[k]);
      if (k == 1) chk_all("resync_next", 2, 1, 8'hB6, 0, 0);
    end
    chk_all("resync_done", 0, 0, 8'h3C, 1, 0);

    // reset at slot 4, then a full frame
    pat = 8'h5A;
    for (int k = 0; k < 4; k++) step(0, 1, k == 0, pat[k]);
    step(1, 1, 0, pat[4]);
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    pat = 8'hB6;
    for (int k = 0; k < 8; k++) step(0, 1, k == 0, pat[k]);
    chk_all("rst_after", 0, 0, 8'hB6, 1, 0);

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      step(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0, 1'($urandom));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tdm_demux8
